// File: rtl/uart_pkg.sv
// Shared definitions for the UART FIFO bridge.
// TX sequencer states and status-word bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_WAIT  = 2'd2
    } tx_state_e;

    localparam int ST_TX_IDLE = 0;
    localparam int ST_RX_TO   = 1;
    localparam int ST_RX_OVF  = 2;
    localparam int ST_TX_OVF  = 3;

endpackage

// File: rtl/uart_fifo_core.sv
// Power-of-two FIFO with registered count and first-word fall-through.
// Flush wins over push/pop; push on full is accepted only with a real pop.
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_mem[r_rptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Per-channel buffering between the UART bit engines and the CSR block:
// RX FIFO with threshold/timeout interrupt, TX FIFO with drain sequencer.
module uart_fifo_bridge
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RX_DEPTH   = 16,
    parameter int TX_DEPTH   = 16,
    parameter int TO_WIDTH   = 16
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          rx_valid_i,
    input  logic [DATA_WIDTH-1:0]         rx_data_i,
    output logic                          rx_ack_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    output logic                          tx_start_o,
    input  logic                          tx_clear_i,
    input  logic                          tx_busy_i,
    input  logic                          rx_pop_i,
    output logic [DATA_WIDTH-1:0]         rx_head_o,
    output logic [$clog2(RX_DEPTH+1)-1:0] rx_count_o,
    input  logic                          tx_push_i,
    input  logic [DATA_WIDTH-1:0]         tx_wdata_i,
    output logic [$clog2(TX_DEPTH+1)-1:0] tx_count_o,
    input  logic                          rx_flush_i,
    input  logic                          tx_flush_i,
    input  logic                          irq_en_i,
    input  logic [$clog2(RX_DEPTH+1)-1:0] thresh_i,
    input  logic [TO_WIDTH-1:0]           timeout_i,
    input  logic                          ovf_clr_i,
    output logic [3:0]                    status_o,
    output logic                          irq_o
);

    logic                  w_rx_full;
    logic                  w_rx_empty;
    logic                  w_tx_full;
    logic                  w_tx_empty;
    logic [DATA_WIDTH-1:0] w_tx_head;
    logic                  w_tx_pop;
    logic                  w_tx_start;
    logic                  w_tx_idle;
    logic                  w_rx_ovf_set;
    logic                  w_tx_ovf_set;
    logic                  w_rx_act;
    logic                  w_thr_hit;
    logic [TO_WIDTH-1:0]   w_to_nxt;
    tx_state_e             r_state;
    tx_state_e             w_state_nxt;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_rx_ack;
    logic                  r_rx_ovf;
    logic                  r_tx_ovf;
    logic                  r_rx_to;
    logic [TO_WIDTH-1:0]   r_to_cnt;
    logic                  r_irq;

    uart_fifo_core #(.DEPTH(RX_DEPTH), .WIDTH(DATA_WIDTH)) u_rx_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (rx_valid_i),
        .pop   (rx_pop_i),
        .flush (rx_flush_i),
        .din   (rx_data_i),
        .dout  (rx_head_o),
        .count (rx_count_o),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    uart_fifo_core #(.DEPTH(TX_DEPTH), .WIDTH(DATA_WIDTH)) u_tx_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (tx_push_i),
        .pop   (w_tx_pop),
        .flush (tx_flush_i),
        .din   (tx_wdata_i),
        .dout  (w_tx_head),
        .count (tx_count_o),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    assign w_rx_ovf_set = rx_valid_i & w_rx_full & ~rx_pop_i;
    assign w_tx_ovf_set = tx_push_i & w_tx_full & ~w_tx_pop;
    assign w_rx_act     = rx_valid_i | rx_pop_i | rx_flush_i;
    assign w_to_nxt     = r_to_cnt + TO_WIDTH'(1);
    assign w_thr_hit    = (thresh_i != '0) && (rx_count_o >= thresh_i);
    assign w_tx_idle    = (r_state == TX_IDLE) & w_tx_empty;

    always_comb begin
        w_state_nxt = r_state;
        w_tx_pop    = 1'b0;
        w_tx_start  = 1'b0;
        unique case (r_state)
            TX_IDLE: begin
                // A flush in the same cycle empties the FIFO, so hold off.
                if (!w_tx_empty && !tx_busy_i && !tx_flush_i) begin
                    w_tx_pop    = 1'b1;
                    w_state_nxt = TX_START;
                end
            end
            TX_START: begin
                w_tx_start  = 1'b1;
                w_state_nxt = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_clear_i) w_state_nxt = TX_IDLE;
            end
            default: w_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= TX_IDLE;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_tx_pop) r_tx_data <= w_tx_head;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rx_ack <= 1'b0;
            r_rx_ovf <= 1'b0;
            r_tx_ovf <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_rx_ack <= rx_valid_i;
            r_rx_ovf <= w_rx_ovf_set | (r_rx_ovf & ~ovf_clr_i);
            r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~ovf_clr_i);
            r_irq    <= irq_en_i & (w_thr_hit | r_rx_to | r_rx_ovf | r_tx_ovf);
        end
    end

    // Idle timer saturates at timeout_i so the flag stays until activity.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_to_cnt <= '0;
            r_rx_to  <= 1'b0;
        end else if (w_rx_act) begin
            r_to_cnt <= '0;
            r_rx_to  <= 1'b0;
        end else if (!w_rx_empty && timeout_i != '0 && r_to_cnt < timeout_i) begin
            r_to_cnt <= w_to_nxt;
            if (w_to_nxt == timeout_i) r_rx_to <= 1'b1;
        end
    end

    assign rx_ack_o   = r_rx_ack;
    assign tx_data_o  = r_tx_data;
    assign tx_start_o = w_tx_start;
    assign irq_o      = r_irq;
    assign status_o   = {r_tx_ovf, r_rx_ovf, r_rx_to, w_tx_idle};

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench for uart_fifo_bridge: directed scenarios then random traffic.
// Expected data/flags come from queues and an integer reference model.
module tb_uart_fifo_bridge;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       wb_rst_i;
    logic       rx_valid_i;
    logic [7:0] rx_data_i;
    logic       rx_ack_o;
    logic [7:0] tx_data_o;
    logic       tx_start_o;
    logic       tx_clear_i;
    logic       tx_busy_i;
    logic       rx_pop_i;
    logic [7:0] rx_head_o;
    logic [4:0] rx_count_o;
    logic       tx_push_i;
    logic [7:0] tx_wdata_i;
    logic [4:0] tx_count_o;
    logic       rx_flush_i;
    logic       tx_flush_i;
    logic       irq_en_i;
    logic [4:0] thresh_i;
    logic [15:0] timeout_i;
    logic       ovf_clr_i;
    logic [3:0] status_o;
    logic       irq_o;

    uart_fifo_bridge dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wb_rst_i),
        .rx_valid_i(rx_valid_i),
        .rx_data_i (rx_data_i),
        .rx_ack_o  (rx_ack_o),
        .tx_data_o (tx_data_o),
        .tx_start_o(tx_start_o),
        .tx_clear_i(tx_clear_i),
        .tx_busy_i (tx_busy_i),
        .rx_pop_i  (rx_pop_i),
        .rx_head_o (rx_head_o),
        .rx_count_o(rx_count_o),
        .tx_push_i (tx_push_i),
        .tx_wdata_i(tx_wdata_i),
        .tx_count_o(tx_count_o),
        .rx_flush_i(rx_flush_i),
        .tx_flush_i(tx_flush_i),
        .irq_en_i  (irq_en_i),
        .thresh_i  (thresh_i),
        .timeout_i (timeout_i),
        .ovf_clr_i (ovf_clr_i),
        .status_o  (status_o),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    int tx_out = 0;
    int starts = 0;
    int ack_cnt = 0;
    int eng_len = 3;
    logic prev_valid = 1'b0;
    logic [7:0] last_tx;
    logic last_ok = 1'b0;

    int   m_cnt;
    int   m_idle;
    logic m_ovf;
    logic m_to;
    logic m_irq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model of RX occupancy, overflow, idle timeout and irq.
    always @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            m_cnt  <= 0;
            m_idle <= 0;
            m_ovf  <= 1'b0;
            m_to   <= 1'b0;
            m_irq  <= 1'b0;
        end else begin
            m_irq <= irq_en_i && ((thresh_i != 0 && m_cnt >= int'(thresh_i)) || m_to || m_ovf);
            if (rx_flush_i)
                m_cnt <= 0;
            else if (rx_valid_i && !(m_cnt == D && !rx_pop_i))
                m_cnt <= m_cnt + 1 - ((rx_pop_i && m_cnt > 0) ? 1 : 0);
            else if (rx_pop_i && m_cnt > 0)
                m_cnt <= m_cnt - 1;
            m_ovf <= (rx_valid_i && m_cnt == D && !rx_pop_i) || (m_ovf && !ovf_clr_i);
            if (rx_valid_i || rx_pop_i || rx_flush_i) begin
                m_idle <= 0;
                m_to   <= 1'b0;
            end else if (m_cnt > 0 && timeout_i != 0 && m_idle < int'(timeout_i)) begin
                m_idle <= m_idle + 1;
                if (m_idle + 1 == int'(timeout_i)) m_to <= 1'b1;
            end
        end
    end

    // Monitor: compares DUT outputs with scoreboard queues and model.
    always @(negedge clk) begin
        if (wb_rst_i) begin
            prev_valid = 1'b0;
        end else begin
            chk("rx_ack", rx_ack_o, prev_valid);
            if (rx_ack_o) ack_cnt++;
            prev_valid = rx_valid_i;
            chk("rx_count", rx_count_o, m_cnt);
            chk("irq", irq_o, m_irq);
            chk("status_flags", status_o[3:1], {1'b0, m_ovf, m_to});
            if (rx_pop_i && !rx_flush_i && rxq.size() > 0)
                chk("rx_head", rx_head_o, rxq.pop_front());
            if (tx_start_o) begin
                starts++;
                if (txq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_start unexpected data=%0h t=%0t", tx_data_o, $time);
                end else begin
                    last_tx = txq.pop_front();
                    tx_out--;
                    chk("tx_data", tx_data_o, last_tx);
                    last_ok = 1'b1;
                end
            end
            if (tx_clear_i && last_ok) begin
                chk("tx_hold", tx_data_o, last_tx);
                last_ok = 1'b0;
            end
        end
    end

    // Transmit engine model: busy for eng_len cycles, then clear pulse.
    initial begin
        tx_busy_i  = 1'b0;
        tx_clear_i = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start_o) begin
                @(posedge clk); #1;
                tx_busy_i = 1'b1;
                repeat (eng_len) @(posedge clk);
                #1;
                tx_busy_i  = 1'b0;
                tx_clear_i = 1'b1;
                @(posedge clk); #1;
                tx_clear_i = 1'b0;
            end
        end
    end

    task automatic rx_send(input logic [7:0] d);
        @(posedge clk); #1;
        rx_valid_i = 1'b1;
        rx_data_i  = d;
        if (rxq.size() < D) rxq.push_back(d);
    endtask

    task automatic tx_send(input logic [7:0] d);
        @(posedge clk); #1;
        tx_push_i  = 1'b1;
        tx_wdata_i = d;
        txq.push_back(d);
        tx_out++;
    endtask

    task automatic idle_in;
        @(posedge clk); #1;
        rx_valid_i = 1'b0;
        rx_pop_i   = 1'b0;
        tx_push_i  = 1'b0;
        rx_flush_i = 1'b0;
        tx_flush_i = 1'b0;
        ovf_clr_i  = 1'b0;
    endtask

    task automatic rx_flush;
        @(posedge clk); #1;
        rx_flush_i = 1'b1;
        rxq.delete();
        idle_in();
    endtask

    task automatic wait_start(input int s0, input string nm);
        int i;
        for (i = 0; i < 20 && starts == s0; i++) @(negedge clk);
        chk(nm, (starts > s0), 1'b1);
    endtask

    logic v, p, fl;
    int s0, a0;

    initial begin
        wb_rst_i = 1'b1;
        rx_valid_i = 0; rx_data_i = 0; rx_pop_i = 0; tx_push_i = 0;
        tx_wdata_i = 0; rx_flush_i = 0; tx_flush_i = 0; irq_en_i = 0;
        thresh_i = 0; timeout_i = 0; ovf_clr_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_status", status_o, 4'b0001);
        chk("rst_irq", irq_o, 1'b0);
        chk("rst_start", tx_start_o, 1'b0);
        chk("rst_ack", rx_ack_o, 1'b0);
        chk("rst_txdata", tx_data_o, 8'h00);
        chk("rst_rxcnt", rx_count_o, 5'd0);
        chk("rst_txcnt", tx_count_o, 5'd0);
        wb_rst_i = 1'b0;

        // Single TX character: start two cycles after the push.
        tx_send(8'h41);
        idle_in();
        @(negedge clk);
        chk("tx_lat_early", tx_start_o, 1'b0);
        @(negedge clk);
        chk("tx_lat_start", tx_start_o, 1'b1);
        chk("tx_lat_data", tx_data_o, 8'h41);
        for (int i = 0; i < 30 && !status_o[0]; i++) @(negedge clk);
        chk("tx_idle_after", status_o[0], 1'b1);

        // Threshold interrupt.
        irq_en_i = 1'b1;
        thresh_i = 5'd4;
        for (int i = 0; i < 4; i++) rx_send(8'($urandom));
        idle_in();
        @(negedge clk);
        chk("thr_cnt4", rx_count_o, 5'd4);
        chk("thr_irq_lag", irq_o, 1'b0);
        @(negedge clk);
        chk("thr_irq_rise", irq_o, 1'b1);
        @(posedge clk); #1;
        rx_pop_i = 1'b1;
        idle_in();
        @(negedge clk);
        chk("thr_irq_hold", irq_o, 1'b1);
        @(negedge clk);
        chk("thr_irq_fall", irq_o, 1'b0);
        rx_flush();
        thresh_i = 5'd0;

        // Idle timeout of 100 cycles.
        timeout_i = 16'd100;
        rx_send(8'h5a);
        @(posedge clk); #1;
        rx_valid_i = 1'b0;
        repeat (99) @(posedge clk);
        @(negedge clk);
        chk("to_early", status_o[1], 1'b0);
        @(negedge clk);
        chk("to_set", status_o[1], 1'b1);
        @(negedge clk);
        chk("to_irq", irq_o, 1'b1);
        @(posedge clk); #1;
        rx_pop_i = 1'b1;
        idle_in();
        @(negedge clk);
        chk("to_clear", status_o[1], 1'b0);
        @(negedge clk);
        chk("to_irq_clear", irq_o, 1'b0);
        timeout_i = 16'd0;

        // RX overflow: 17 characters into 16 entries.
        a0 = ack_cnt;
        for (int i = 0; i < 17; i++) rx_send(8'($urandom));
        idle_in();
        repeat (2) @(negedge clk);
        chk("ovf_acks", ack_cnt - a0, 17);
        chk("ovf_cnt", rx_count_o, 5'd16);
        chk("ovf_flag", status_o[2], 1'b1);
        @(posedge clk); #1;
        ovf_clr_i = 1'b1;
        idle_in();
        @(negedge clk);
        chk("ovf_clr", status_o[2], 1'b0);
        rx_flush();

        // TX flush while the first character is in WAIT.
        eng_len = 20;
        s0 = starts;
        tx_send(8'h11);
        tx_send(8'h22);
        tx_send(8'h33);
        idle_in();
        wait_start(s0, "fl_first_start");
        @(posedge clk); #1;
        tx_flush_i = 1'b1;
        txq.delete();
        tx_out = 0;
        idle_in();
        @(negedge clk);
        chk("fl_txcnt", tx_count_o, 5'd0);
        repeat (40) @(negedge clk);
        chk("fl_one_start", starts - s0, 1);
        chk("fl_idle", status_o[0], 1'b1);

        // Asynchronous reset during WAIT with both FIFOs holding data.
        s0 = starts;
        tx_send(8'h77);
        rx_valid_i = 1'b1; rx_data_i = 8'h01; rxq.push_back(8'h01);
        tx_send(8'h78);
        rx_data_i = 8'h02; rxq.push_back(8'h02);
        tx_send(8'h79);
        idle_in();
        wait_start(s0, "rst_first_start");
        @(posedge clk); #3;
        wb_rst_i = 1'b1;
        #1;
        chk("arst_status", status_o, 4'b0001);
        chk("arst_start", tx_start_o, 1'b0);
        chk("arst_ack", rx_ack_o, 1'b0);
        chk("arst_txdata", tx_data_o, 8'h00);
        chk("arst_irq", irq_o, 1'b0);
        chk("arst_rxcnt", rx_count_o, 5'd0);
        chk("arst_txcnt", tx_count_o, 5'd0);
        rxq.delete();
        txq.delete();
        tx_out = 0;
        last_ok = 1'b0;
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        s0 = starts;
        repeat (40) @(posedge clk);
        chk("arst_no_start", starts - s0, 0);

        // Random traffic.
        eng_len = 3;
        for (int c = 0; c < 2400; c++) begin
            @(posedge clk); #1;
            if (c % 400 == 0) begin
                thresh_i  = 5'($urandom_range(1, 16));
                timeout_i = 16'($urandom_range(4, 40));
            end
            v  = (c < 1200) ? ($urandom % 2 == 0) : ($urandom % 4 == 0);
            p  = (c < 1200) ? ($urandom % 4 == 0) : ($urandom % 2 == 0);
            fl = ($urandom % 150 == 0);
            p  = p && rxq.size() > 0 && !fl;
            rx_valid_i = v;
            rx_data_i  = 8'($urandom);
            rx_pop_i   = p;
            rx_flush_i = fl;
            ovf_clr_i  = ($urandom % 40 == 0);
            if (fl) rxq.delete();
            else if (v && (rxq.size() < D || p)) rxq.push_back(rx_data_i);
            if ($urandom % 5 == 0 && tx_out < 15) begin
                tx_push_i  = 1'b1;
                tx_wdata_i = 8'($urandom);
                txq.push_back(tx_wdata_i);
                tx_out++;
            end else begin
                tx_push_i = 1'b0;
            end
        end
        idle_in();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            rx_pop_i = (rxq.size() > 0);
        end
        idle_in();
        for (int i = 0; i < 600 && !(txq.size() == 0 && status_o[0]); i++) @(negedge clk);
        chk("drain_tx", {txq.size() == 0, status_o[0]}, 2'b11);
        @(negedge clk);
        chk("drain_rxcnt", rx_count_o, 5'd0);
        chk("drain_txcnt", tx_count_o, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
- Parametrised buffering and interrupt layer between the UART bit engines (uart_receive / uart_transmission) and the Wishbone CSR block.
- Replaces fixed batch-of-8 buffering with continuous-drain TX and threshold-plus-timeout RX interrupts, configurable FIFO depths, sticky overflow flags and synchronous flushes.
- One instance per UART channel.

Parameters:
- DATA_WIDTH, 8: character width in bits.
- RX_DEPTH, 16: RX FIFO entries; power of two, ≥2.
- TX_DEPTH, 16: TX FIFO entries; power of two, ≥2.
- TO_WIDTH, 16: width of the RX idle-timeout counter and of timeout_i.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- rx_valid_i  in  1  engine pulse: character received.
- rx_data_i  in  DATA_WIDTH  received character, valid with rx_valid_i.
- rx_ack_o  out  1  pulse to engine: character consumed (engine rx_finish).
- tx_data_o  out  DATA_WIDTH  character to engine, held until tx_clear_i.
- tx_start_o  out  1  one-cycle start pulse to engine.
- tx_clear_i  in  1  engine pulse: transmission done.
- tx_busy_i  in  1  engine busy.
- rx_pop_i  in  1  host read-pop.
- rx_head_o  out  DATA_WIDTH  RX FIFO head (first-word fall-through).
- rx_count_o  out  $clog2(RX_DEPTH+1)  RX occupancy.
- tx_push_i  in  1  host write-push.
- tx_wdata_i  in  DATA_WIDTH  push data.
- tx_count_o  out  $clog2(TX_DEPTH+1)  TX occupancy.
- rx_flush_i, tx_flush_i  in  1 each  synchronous FIFO clear.
- irq_en_i  in  1  interrupt enable.
- thresh_i  in  $clog2(RX_DEPTH+1)  RX level threshold; 0 disables.
- timeout_i  in  TO_WIDTH  idle cycles before timeout irq; 0 disables.
- ovf_clr_i  in  1  clears sticky overflow flags.
- status_o  out  4  {tx_ovf, rx_ovf, rx_timeout, tx_idle}.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset (async, any state, mid-character included): both FIFOs empty, all counts 0, flags 0, TX FSM to IDLE. Reset values: tx_start_o=0, rx_ack_o=0, tx_data_o=0, irq_o=0, status_o=4'b0001.
- RX write: rx_valid_i writes rx_data_i when not full. If full, the character is dropped and rx_ovf is set. Write with pop on a full FIFO is accepted; count unchanged.
- rx_ack_o pulses exactly one cycle after every rx_valid_i, stored or dropped.
- RX read: rx_head_o is valid when rx_count_o>0. rx_pop_i on empty is ignored. Registered count: push at cycle t gives rx_count_o updated at t+1.
- rx_flush_i: empties RX, clears rx_timeout, and has priority over a same-cycle push or pop.
- Timeout counter:
  - Counts cycles while RX is non-empty with no push and no pop.
  - Reset to 0 by any push, pop or flush.
  - When it reaches timeout_i (non-zero), rx_timeout sets and the counter saturates.
  - rx_timeout clears on the next pop, push or flush.
- irq_o (registered) = irq_en_i & ((thresh_i!=0 & rx_count≥thresh_i) | rx_timeout | rx_ovf | tx_ovf).
- TX push: tx_push_i on full drops the data and sets tx_ovf. Push with the FSM pop on a full FIFO is accepted.
- TX FSM:
  - IDLE: if FIFO non-empty and !tx_busy_i, latch head into tx_data_o, pop, go to START.
  - START: tx_start_o=1 for one cycle, go to WAIT.
  - WAIT: on tx_clear_i go to IDLE. tx_data_o is stable throughout WAIT.
  - Latency: push into empty FIFO at t gives tx_start_o at t+2. Back-to-back characters are separated by tx_clear_i→IDLE→START, i.e. 2 cycles after clear.
- tx_flush_i: empties TX FIFO only. An in-flight character (START/WAIT) completes normally.
- tx_idle = FSM in IDLE & TX FIFO empty.
- ovf_clr_i clears both ovf flags. A same-cycle new overflow wins and the flag stays set.
- Pointers wrap modulo depth. Counts saturate by construction: no push when full without a pop.

Decomposition:
- Shared package uart_pkg: TX FSM state encoding (IDLE=2'd0, START=2'd1, WAIT=2'd2) and status bit indices.
- One sub-module, uart_fifo_core, instantiated twice:
  - Parameters DEPTH, WIDTH.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - Registered count, FWFT output.

Test Plan:
- Push 0x41 into idle TX with tx_busy_i=0 → tx_start_o at t+2 with tx_data_o=0x41. After tx_clear_i, tx_idle=1.
- RX_DEPTH=16, thresh_i=4, irq_en_i=1: send 4 rx_valid_i → irq_o rises the cycle after the 4th count. One pop → irq_o falls.
- timeout_i=100, one RX char, no pop → rx_timeout and irq_o set at idle cycle 100. Pop → both clear.
- 17 rx_valid_i into empty 16-deep RX → 17 rx_ack_o pulses, count 16, rx_ovf=1. ovf_clr_i → rx_ovf=0.
- Push 3 TX chars, assert tx_flush_i during the first char's WAIT → first char completes, no further tx_start_o, tx_count_o=0.
- Assert wb_rst_i mid-WAIT with both FIFOs non-empty → immediate reset values, status_o=4'b0001, no tx_start_o after release.
